hilo_muldiv: RTL and testbench

//   HI/LO register pair with a built-in iterative multiply/divide engine.

---
 rtl/hilo_muldiv.sv | 127 ++++++++++++
 tb/tb_hilo_muldiv.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - HI/LO register pair with iterative signed/unsigned multiply and restoring divide
// Optional HILO_FWD_EN: combinational write-through of hi_in/lo_in on direct writes in IDLE.
module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             is_div, neg_q, neg_r, dz;
  logic [WIDTH-1:0] hi_q, lo_q, acc_hi, acc_lo, opb, a_raw;

  logic             sa, sb;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum, rem_sh, trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  always_comb begin
    sa       = ~op[0] & a[WIDTH-1];
    sb       = ~op[0] & b[WIDTH-1];
    abs_a    = sa ? -a : a;
    abs_b    = sb ? -b : b;
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    // Remainder stays below the divisor, so the shifted value fits in WIDTH+1 bits.
    rem_sh   = {acc_hi, acc_lo[WIDTH-1]};
    trial    = rem_sh - {1'b0, opb};
    prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    quo_fix  = neg_q ? -acc_lo : acc_lo;
    rem_fix  = neg_r ? -acc_hi : acc_hi;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      opb         <= '0;
      a_raw       <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi_q <= hi_in;
          if (lo_we) lo_q <= lo_in;
          if (start) begin
            is_div <= op[1];
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            dz     <= op[1] & (b == '0);
            acc_hi <= '0;
            acc_lo <= abs_a;
            opb    <= abs_b;
            a_raw  <= a;
            cnt    <= CW'(WIDTH);
            state  <= CALC;
          end
        end
        CALC: begin
          if (is_div) begin
            acc_hi <= trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], ~trial[WIDTH]};
          end else begin
            {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
          end
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          if (!is_div) begin
            {hi_q, lo_q} <= prod_fix;
          end else if (dz) begin
            hi_q <= a_raw;
            lo_q <= '1;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end
          done        <= 1'b1;
          div_by_zero <= is_div & dz;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

`ifdef HILO_FWD_EN
  assign hi_out = (state == IDLE && hi_we) ? hi_in : hi_q;
  assign lo_out = (state == IDLE && lo_we) ? lo_in : lo_q;
`else
  assign hi_out = hi_q;
  assign lo_out = lo_q;
`endif

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb/tb_hilo_muldiv.sv - directed self-checking bench for hilo_muldiv (WIDTH=32)
module tb_hilo_muldiv;

  logic        clk = 1'b0;
  logic        rst, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] a, b, hi_in, lo_in, hi_out, lo_out;
  logic        busy, done, div_by_zero;

  int vecs = 0;
  int errs = 0;

  hilo_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .hi_in(hi_in), .lo_in(lo_in),
    .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Launch an op and wait (bounded) for done; reports cycles-to-done and busy cycles.
  task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                        output int cyc, output int bcyc, output logic dz_seen);
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 0; bcyc = 0; dz_seen = 1'b0;
    while (!done && cyc < 100) begin
      if (busy) bcyc++;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    dz_seen = div_by_zero;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vecs++;
    if ({hi_out, lo_out, busy, done, div_by_zero} !== 67'd0) begin
      errs++;
      $display("FAIL reset: hi=%h lo=%h busy=%b done=%b dz=%b expected all zero",
               hi_out, lo_out, busy, done, div_by_zero);
    end
    rst = 1'b1;
  endtask

  task automatic test_multu;
    int c, bc; logic z;
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c, bc, z);
    vecs++;
    if (c !== 33) begin errs++; $display("FAIL multu_latency: got %0d expected 33", c); end
    vecs++;
    if (bc !== 33) begin errs++; $display("FAIL multu_busy_cycles: got %0d expected 33", bc); end
    vecs++;
    if ({hi_out, lo_out} !== 64'hFFFF_FFFE_0000_0001) begin
      errs++; $display("FAIL multu_result: got %h_%h expected fffffffe_00000001", hi_out, lo_out);
    end
    @(negedge clk);
    vecs++;
    if ({done, busy} !== 2'b00) begin
      errs++; $display("FAIL done_pulse_width: done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_mult;
    int c, bc; logic z;
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, c, bc, z);
    vecs++;
    if ({hi_out, lo_out} !== 64'hFFFF_FFFF_FFFF_FFF1) begin
      errs++; $display("FAIL mult_neg3x5: got %h_%h expected ffffffff_fffffff1", hi_out, lo_out);
    end
    run_op(2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFD, c, bc, z);
    vecs++;
    if ({hi_out, lo_out} !== 64'h0000_0000_0000_0006) begin
      errs++; $display("FAIL mult_neg2xneg3: got %h_%h expected 00000000_00000006", hi_out, lo_out);
    end
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, c, bc, z);
    vecs++;
    if ({hi_out, lo_out} !== 64'h4000_0000_0000_0000) begin
      errs++; $display("FAIL mult_minxmin: got %h_%h expected 40000000_00000000", hi_out, lo_out);
    end
  endtask

  task automatic test_div;
    int c, bc; logic z;
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, c, bc, z);
    vecs++;
    if ({hi_out, lo_out, z} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0}) begin
      errs++; $display("FAIL div_neg7by2: got hi=%h lo=%h dz=%b expected ffffffff fffffffd 0",
                       hi_out, lo_out, z);
    end
    vecs++;
    if (c !== 33) begin errs++; $display("FAIL div_latency: got %0d expected 33", c); end
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, c, bc, z);
    vecs++;
    if ({hi_out, lo_out} !== {32'd1, 32'hFFFF_FFFD}) begin
      errs++; $display("FAIL div_7byneg2: got hi=%h lo=%h expected 00000001 fffffffd", hi_out, lo_out);
    end
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, c, bc, z);
    vecs++;
    if ({hi_out, lo_out, z} !== {32'd0, 32'h8000_0000, 1'b0}) begin
      errs++; $display("FAIL div_min_by_neg1: got hi=%h lo=%h dz=%b expected 00000000 80000000 0",
                       hi_out, lo_out, z);
    end
    run_op(2'b11, 32'hFFFF_FFF9, 32'd16, c, bc, z);
    vecs++;
    if ({hi_out, lo_out} !== {32'd9, 32'h0FFF_FFFF}) begin
      errs++; $display("FAIL divu_big: got hi=%h lo=%h expected 00000009 0fffffff", hi_out, lo_out);
    end
  endtask

  task automatic test_div_zero;
    int c, bc; logic z;
    run_op(2'b11, 32'd10, 32'd0, c, bc, z);
    vecs++;
    if ({hi_out, lo_out, z} !== {32'h0000_000A, 32'hFFFF_FFFF, 1'b1}) begin
      errs++; $display("FAIL divu_by_zero: got hi=%h lo=%h dz=%b expected 0000000a ffffffff 1",
                       hi_out, lo_out, z);
    end
    @(negedge clk);
    vecs++;
    if (div_by_zero !== 1'b0) begin
      errs++; $display("FAIL dz_pulse_width: got %b expected 0", div_by_zero);
    end
    run_op(2'b10, 32'hFFFF_FFF0, 32'd0, c, bc, z);
    vecs++;
    if ({hi_out, lo_out, z} !== {32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1}) begin
      errs++; $display("FAIL div_signed_by_zero: got hi=%h lo=%h dz=%b expected fffffff0 ffffffff 1",
                       hi_out, lo_out, z);
    end
  endtask

  task automatic test_direct_write;
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; hi_in = 32'hCAFE_0001; lo_in = 32'hBEEF_0002;
    #1;
    vecs++;
`ifdef HILO_FWD_EN
    if ({hi_out, lo_out} !== {32'hCAFE_0001, 32'hBEEF_0002}) begin
      errs++; $display("FAIL fwd_same_cycle: got %h %h expected cafe0001 beef0002", hi_out, lo_out);
    end
`else
    if ({hi_out, lo_out} !== {32'hFFFF_FFF0, 32'hFFFF_FFFF}) begin
      errs++; $display("FAIL write_not_early: got %h %h expected fffffff0 ffffffff", hi_out, lo_out);
    end
`endif
    @(posedge clk);
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    #1;
    vecs++;
    if ({hi_out, lo_out} !== {32'hCAFE_0001, 32'hBEEF_0002}) begin
      errs++; $display("FAIL mthi_mtlo: got %h %h expected cafe0001 beef0002", hi_out, lo_out);
    end
  endtask

  task automatic test_write_with_start;
    int c;
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd6; b = 32'd7; hi_we = 1'b1; hi_in = 32'h5555_AAAA;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    vecs++;
    if (hi_out !== 32'h5555_AAAA) begin
      errs++; $display("FAIL write_at_e0: got %h expected 5555aaaa", hi_out);
    end
    // A second start mid-operation must be ignored.
    repeat (5) @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (!done && c < 100) begin @(negedge clk); c++; end
    vecs++;
    if ({hi_out, lo_out} !== {32'd0, 32'd42}) begin
      errs++; $display("FAIL result_overwrites_write: got %h %h expected 00000000 0000002a", hi_out, lo_out);
    end
    @(negedge clk);
    vecs++;
    if (busy !== 1'b0) begin
      errs++; $display("FAIL start_while_busy_queued: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_back_to_back;
    int c, bc; logic z;
    run_op(2'b01, 32'd1000, 32'd1000, c, bc, z);
    run_op(2'b11, 32'd1000, 32'd7, c, bc, z);
    vecs++;
    if ({hi_out, lo_out, c} !== {32'd6, 32'd142, 32'd33}) begin
      errs++; $display("FAIL back_to_back: got hi=%h lo=%h cyc=%0d expected 00000006 0000008e 33",
                       hi_out, lo_out, c);
    end
  endtask

  task automatic test_abort;
    int seen;
    logic [31:0] hi_prev, lo_prev;
    hi_prev = hi_out; lo_prev = lo_out;
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    hi_we = 1'b1; hi_in = 32'h0000_1234;
    @(negedge clk);
    hi_we = 1'b0;
    vecs++;
    if ({hi_out, lo_out} !== {hi_prev, lo_prev}) begin
      errs++; $display("FAIL mthi_while_busy: got %h %h expected %h %h", hi_out, lo_out, hi_prev, lo_prev);
    end
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    vecs++;
    if ({hi_out, lo_out, busy, done} !== 66'd0) begin
      errs++; $display("FAIL abort_state: hi=%h lo=%h busy=%b done=%b expected all zero",
                       hi_out, lo_out, busy, done);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    vecs++;
    if (seen !== 0) begin
      errs++; $display("FAIL abort_done_pulse: got %0d done pulses expected 0", seen);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; hi_in = '0; lo_in = '0;
    test_reset;
    test_multu;
    test_mult;
    test_div;
    test_div_zero;
    test_direct_write;
    test_write_with_start;
    test_back_to_back;
    test_abort;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
